// File: rtl/prim_ram_2p_pkg.sv
// Shared types for the two-port RAM primitive and its users.
// ram_2p_cfg_t carries implementation-specific RAM tuning bits (e.g. timing
// margin controls on a hard macro). The generic model accepts but ignores it.
package prim_ram_2p_pkg;

  typedef struct packed {
    logic       cfg_en;
    logic [3:0] cfg;
  } ram_2p_cfg_t;

  localparam ram_2p_cfg_t RAM_2P_CFG_DEFAULT = '0;

endpackage : prim_ram_2p_pkg

// File: rtl/prim_ram_2p.sv
// Generic two-port RAM: port A is write-only with a bit-level write mask,
// port B is read-only. Read data appears one cycle after b_req_i and is held
// until the next read on port B.
module prim_ram_2p
  import prim_ram_2p_pkg::*;
#(
  parameter int Width = 32,
  parameter int Depth = 512,
  localparam int Aw   = $clog2(Depth)
) (
  input  logic             clk_a_i,
  input  logic             clk_b_i,
  input  logic             a_req_i,
  input  logic [Aw-1:0]    a_addr_i,
  input  logic [Width-1:0] a_wdata_i,
  input  logic [Width-1:0] a_wmask_i,
  input  logic             b_req_i,
  input  logic [Aw-1:0]    b_addr_i,
  output logic [Width-1:0] b_rdata_o,
  input  ram_2p_cfg_t      cfg_i
);

  logic [Width-1:0] mem [Depth];
  logic [Width-1:0] b_rdata_q;

  // The generic model has no tunable timing, so the config bits are dropped.
  logic unused_cfg;
  assign unused_cfg = ^cfg_i;

  // Port A: masked write into the array.
  always_ff @(posedge clk_a_i) begin
    if (a_req_i) begin
      mem[a_addr_i] <= (mem[a_addr_i] & ~a_wmask_i) | (a_wdata_i & a_wmask_i);
    end
  end

  // Port B: registered read, output held between reads.
  always_ff @(posedge clk_b_i) begin
    if (b_req_i) begin
      b_rdata_q <= mem[b_addr_i];
    end
  end

  assign b_rdata_o = b_rdata_q;

endmodule : prim_ram_2p

// File: rtl/prim_ram_2p_fifo.sv
// Single-clock FIFO built on one prim_ram_2p instance plus the RAM's own
// output register, giving a capacity of Depth+1 entries.
// Optional feature macro: PRIM_RAM_2P_FIFO_ALMOST_EN adds almost_full_o and
// almost_empty_o, both decoded from registered occupancy.
module prim_ram_2p_fifo
  import prim_ram_2p_pkg::*;
#(
  parameter int Width         = 32,
  parameter int Depth         = 512,
  parameter int AlmostFullTh  = Depth - 4,
  parameter int AlmostEmptyTh = 2,
  localparam int Aw           = $clog2(Depth),
  localparam int DepthW       = $clog2(Depth + 2)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              wvalid_i,
  output logic              wready_o,
  input  logic [Width-1:0]  wdata_i,
  output logic              rvalid_o,
  input  logic              rready_i,
  output logic [Width-1:0]  rdata_o,
  output logic [DepthW-1:0] depth_o,
  input  ram_2p_cfg_t       cfg_i
`ifdef PRIM_RAM_2P_FIFO_ALMOST_EN
  ,
  output logic              almost_full_o,
  output logic              almost_empty_o
`endif
);

  // Handshake: a push happens on a cycle with wvalid_i && wready_o, a pop on
  // a cycle with rvalid_o && rready_i. wready_o and rvalid_o depend only on
  // registered state, so neither side sees a combinational path from the
  // other side's request; requests without the matching ready/valid are
  // simply ignored.

  localparam logic [DepthW-1:0] DepthCnt = DepthW'(Depth);
  localparam logic [Aw-1:0]     PtrMax   = Aw'(Depth - 1);

  logic [Aw-1:0]     wptr_q, wptr_d;
  logic [Aw-1:0]     rptr_q, rptr_d;
  logic [DepthW-1:0] ram_cnt_q, ram_cnt_d;
  logic              rvalid_q, rvalid_d;

  logic push;
  logic pop;
  logic read_issue;
  logic flush;

  // Pointers wrap explicitly so non-power-of-two depths also work.
  function automatic logic [Aw-1:0] ptr_inc(input logic [Aw-1:0] p);
    return (p == PtrMax) ? '0 : p + 1'b1;
  endfunction

  assign flush    = rst_i || clr_i;
  assign wready_o = (ram_cnt_q != DepthCnt);
  assign push     = wvalid_i && wready_o;
  assign pop      = rvalid_q && rready_i;
  // Refill the output register whenever it is empty or being drained. Since
  // ram_cnt_q counts only entries already in the array, rptr_q never equals
  // the address being written this cycle.
  assign read_issue = (ram_cnt_q != '0) && (!rvalid_q || pop);

  // Next-state for pointers, RAM occupancy and the output-valid flag.
  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    ram_cnt_d = ram_cnt_q;
    rvalid_d  = rvalid_q;

    if (push) begin
      wptr_d = ptr_inc(wptr_q);
    end
    if (read_issue) begin
      rptr_d = ptr_inc(rptr_q);
    end

    case ({push, read_issue})
      2'b10:   ram_cnt_d = ram_cnt_q + 1'b1;
      2'b01:   ram_cnt_d = ram_cnt_q - 1'b1;
      default: ram_cnt_d = ram_cnt_q;
    endcase

    if (read_issue) begin
      rvalid_d = 1'b1;
    end else if (pop) begin
      rvalid_d = 1'b0;
    end
  end

  // State register: reset first, then flush, then normal update.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      ram_cnt_q <= '0;
      rvalid_q  <= 1'b0;
    end else if (clr_i) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      ram_cnt_q <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      ram_cnt_q <= ram_cnt_d;
      rvalid_q  <= rvalid_d;
    end
  end

  // Storage. Accesses are suppressed while flushing so the array is not
  // touched by a request that the control logic is discarding.
  prim_ram_2p #(
    .Width (Width),
    .Depth (Depth)
  ) u_ram (
    .clk_a_i   (clk_i),
    .clk_b_i   (clk_i),
    .a_req_i   (push && !flush),
    .a_addr_i  (wptr_q),
    .a_wdata_i (wdata_i),
    .a_wmask_i ({Width{1'b1}}),
    .b_req_i   (read_issue && !flush),
    .b_addr_i  (rptr_q),
    .b_rdata_o (rdata_o),
    .cfg_i     (cfg_i)
  );

  assign rvalid_o = rvalid_q;
  assign depth_o  = ram_cnt_q + {{(DepthW-1){1'b0}}, rvalid_q};

`ifdef PRIM_RAM_2P_FIFO_ALMOST_EN
  assign almost_full_o  = (depth_o >= DepthW'(AlmostFullTh));
  assign almost_empty_o = (depth_o <= DepthW'(AlmostEmptyTh));
`else
  localparam int unused_thresholds = AlmostFullTh + AlmostEmptyTh;
`endif

endmodule : prim_ram_2p_fifo

// File: tb/tb_prim_ram_2p_fifo.sv
// Bench for prim_ram_2p_fifo: a table of single-cycle vectors followed by
// hand-written fill/drain, streaming, pointer-wrap and flush sequences.
// Inputs are driven and outputs sampled just after each falling edge.
module tb_prim_ram_2p_fifo;
  import prim_ram_2p_pkg::*;

  localparam int Width  = 32;
  localparam int Depth  = 512;
  localparam int DepthW = $clog2(Depth + 2);

  logic              clk = 1'b0;
  logic              rst, clr, wvalid, wready, rvalid, rready;
  logic [Width-1:0]  wdata, rdata;
  logic [DepthW-1:0] depth;
  ram_2p_cfg_t       cfg;
`ifdef PRIM_RAM_2P_FIFO_ALMOST_EN
  logic almost_full, almost_empty;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [Width-1:0] exp_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  prim_ram_2p_fifo #(
    .Width        (Width),
    .Depth        (Depth),
    .AlmostFullTh (508),
    .AlmostEmptyTh(2)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .clr_i    (clr),
    .wvalid_i (wvalid),
    .wready_o (wready),
    .wdata_i  (wdata),
    .rvalid_o (rvalid),
    .rready_i (rready),
    .rdata_o  (rdata),
    .depth_o  (depth),
    .cfg_i    (cfg)
`ifdef PRIM_RAM_2P_FIFO_ALMOST_EN
    ,
    .almost_full_o  (almost_full),
    .almost_empty_o (almost_empty)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // vector table
  typedef struct {
    logic              wv;
    logic [Width-1:0]  wd;
    logic              rr;
    logic              cl;
    logic              erv;
    logic [Width-1:0]  erd;
    logic [DepthW-1:0] ed;
    logic              ewr;
  } vec_t;

  vec_t vecs[12];

  // driver: fill without popping, checking occupancy and flags per push
  task automatic fill(input int n);
    for (int k = 0; k < n; k++) begin
      check("fill_depth", depth, k);
      check("fill_wready", wready, 1);
`ifdef PRIM_RAM_2P_FIFO_ALMOST_EN
      check("fill_almost_full", almost_full, (k >= 508));
      check("fill_almost_empty", almost_empty, (k <= 2));
`endif
      wvalid = 1'b1;
      wdata  = Width'(k);
      exp_q.push_back(Width'(k));
      @(negedge clk);
    end
    wvalid = 1'b0;
  endtask

  // driver: pop until the scoreboard is empty, with a cycle budget
  task automatic drain();
    int guard = 0;
    rready = 1'b1;
    while (exp_q.size() > 0 && guard < Depth + 20) begin
      if (rvalid) check("drain_data", rdata, exp_q.pop_front());
      @(negedge clk);
      guard++;
    end
    rready = 1'b0;
    check("drain_done", exp_q.size(), 0);
    check("drain_empty_depth", depth, 0);
  endtask

  // driver: continuous push and pop of n entries starting from empty
  task automatic stream(input int n, input logic [Width-1:0] base);
    int pushed = 0;
    int popped = 0;
    int cyc    = 0;
    int first  = -1;
    while (popped < n && cyc < n + 20) begin
      if (rvalid) begin
        if (exp_q.size() == 0) begin
          check("stream_unexpected_pop", rvalid, 0);
        end else begin
          check("stream_data", rdata, exp_q.pop_front());
        end
        popped++;
        if (first < 0) first = cyc;
      end else if (first >= 0) begin
        check("stream_gap", rvalid, 1);
      end
      if (pushed < n) begin
        check("stream_wready", wready, 1);
        wvalid = 1'b1;
        wdata  = base + Width'(pushed);
        exp_q.push_back(base + Width'(pushed));
        pushed++;
      end else begin
        wvalid = 1'b0;
      end
      rready = 1'b1;
      @(negedge clk);
      cyc++;
    end
    wvalid = 1'b0;
    rready = 1'b0;
    check("stream_count", popped, n);
    check("stream_first_cycle", first, 2);
    check("stream_last_cycle", cyc, n + 2);
  endtask

  // driver: hold 5 entries, then reset or clear during a push and pop
  task automatic flush_test(input bit use_rst);
    for (int i = 0; i < 5; i++) begin
      wvalid = 1'b1;
      wdata  = 32'h500 + Width'(i);
      @(negedge clk);
    end
    wvalid = 1'b0;
    repeat (2) @(negedge clk);
    check("flush_pre_depth", depth, 5);
    check("flush_pre_rvalid", rvalid, 1);
    wvalid = 1'b1;
    wdata  = 32'h777;
    rready = 1'b1;
    if (use_rst) rst = 1'b1;
    else clr = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clr = 1'b0;
    wvalid = 1'b0;
    rready = 1'b0;
    exp_q.delete();
    check("flush_rvalid", rvalid, 0);
    check("flush_depth", depth, 0);
    check("flush_wready", wready, 1);
    wvalid = 1'b1;
    wdata  = 32'h1234;
    @(negedge clk);
    wvalid = 1'b0;
    repeat (2) @(negedge clk);
    check("flush_after_rvalid", rvalid, 1);
    check("flush_after_rdata", rdata, 32'h1234);
    check("flush_after_depth", depth, 1);
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    check("flush_after_pop_rvalid", rvalid, 0);
    check("flush_after_pop_depth", depth, 0);
  endtask

  initial begin
    //            wv  wd            rr  cl  erv erd           ed  ewr
    vecs[0]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        10'd0, 1'b1};
    vecs[1]  = '{1'b1, 32'hA5A5_0001,1'b0, 1'b0, 1'b0, 32'h0,        10'd0, 1'b1};
    vecs[2]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        10'd1, 1'b1};
    vecs[3]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'hA5A5_0001,10'd1, 1'b1};
    vecs[4]  = '{1'b1, 32'h11,       1'b1, 1'b0, 1'b1, 32'hA5A5_0001,10'd1, 1'b1};
    vecs[5]  = '{1'b1, 32'h22,       1'b1, 1'b0, 1'b0, 32'h0,        10'd1, 1'b1};
    vecs[6]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h11,       10'd2, 1'b1};
    vecs[7]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h22,       10'd1, 1'b1};
    vecs[8]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        10'd0, 1'b1};
    vecs[9]  = '{1'b1, 32'h33,       1'b0, 1'b1, 1'b0, 32'h0,        10'd0, 1'b1};
    vecs[10] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        10'd0, 1'b1};
    vecs[11] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        10'd0, 1'b1};

    rst    = 1'b1;
    clr    = 1'b0;
    wvalid = 1'b0;
    wdata  = '0;
    rready = 1'b0;
    cfg    = RAM_2P_CFG_DEFAULT;
    repeat (3) @(negedge clk);
    rst = 1'b0;

`ifdef PRIM_RAM_2P_FIFO_ALMOST_EN
    check("reset_almost_full", almost_full, 0);
    check("reset_almost_empty", almost_empty, 1);
`endif

    // table-driven single-cycle vectors
    for (int i = 0; i < 12; i++) begin
      wvalid = vecs[i].wv;
      wdata  = vecs[i].wd;
      rready = vecs[i].rr;
      clr    = vecs[i].cl;
      check($sformatf("vec%0d_rvalid", i), rvalid, vecs[i].erv);
      check($sformatf("vec%0d_depth", i), depth, vecs[i].ed);
      check($sformatf("vec%0d_wready", i), wready, vecs[i].ewr);
      if (vecs[i].erv) check($sformatf("vec%0d_rdata", i), rdata, vecs[i].erd);
      @(negedge clk);
    end
    wvalid = 1'b0;
    rready = 1'b0;
    clr    = 1'b0;

    // fill to Depth+1, try an extra push, then drain in order
    fill(Depth + 1);
    check("full_wready", wready, 0);
    check("full_depth", depth, Depth + 1);
`ifdef PRIM_RAM_2P_FIFO_ALMOST_EN
    check("full_almost_full", almost_full, 1);
    check("full_almost_empty", almost_empty, 0);
`endif
    wvalid = 1'b1;
    wdata  = 32'h999;
    @(negedge clk);
    wvalid = 1'b0;
    check("full_extra_depth", depth, Depth + 1);
    check("full_extra_wready", wready, 0);
    drain();

    // sustained throughput, then a run that crosses the pointer wrap again
    stream(1000, 32'h1000_0000);
    stream(610, 32'h2000_0000);

    flush_test(1'b1);
    flush_test(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_prim_ram_2p_fifo
